mips_program_loader: RTL and testbench
======================================

// Module: mips_program_loader
// PURPOSE
//  Synthesizable boot/load sequencer for MIPS_top: accepts a valid/ready word stream,
//  writes words into instruction or data cache with auto-incrementing addresses,
//  then asserts start and supervises the run until the PC leaves the loaded program
//  (done) or a cycle budget expires (timeout). Supports multiple load/run sessions.
// PARAMETERS
//  DATA_W      32   cache data width (IData_in/DData_in)
//  ADDR_W      32   cache address width (IAddr_in/DAddr_in), word-indexed
//  IMEM_DEPTH  64   max instruction words accepted per session
//  DMEM_DEPTH  64   max data words accepted per session
//  START_GAP   2    idle cycles between last write and start assertion (>=1)
//  RUN_CYCLES  300  cycle budget in RUN before timeout (>=1)
//  PC_SHIFT    0    word PC = cpu_pc >> PC_SHIFT (0: word PC, 2: byte PC)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  ld_valid    in   1       load word available
//  ld_ready    out  1       loader can accept a word
//  ld_data     in   DATA_W  word to write
//  ld_dmem     in   1       0: word goes to I-cache, 1: D-cache
//  ld_last     in   1       final word of session
//  cpu_pc      in   ADDR_W  processor current PC
//  IData_in    out  DATA_W  I-cache write data
//  IAddr_in    out  ADDR_W  I-cache write address
//  icache_we   out  1       I-cache write enable
//  DData_in    out  DATA_W  D-cache write data
//  DAddr_in    out  ADDR_W  D-cache write address
//  dcache_we   out  1       D-cache write enable
//  start       out  1       processor run enable (level)
//  done        out  1       run finished by PC exit (sticky till next session)
//  timeout     out  1       run finished by budget expiry (sticky till next session)
//  overflow    out  1       a word beyond IMEM/DMEM_DEPTH was dropped (sticky per session)
//  imem_count  out  ADDR_W  I-words written this session
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except ld_ready=1; counters cleared.
//  - FSM: IDLE -> LOAD -> GAP -> RUN -> DONE; DONE -> LOAD on next accepted word.
//  - Handshake: word accepted when ld_valid & ld_ready. ld_ready=1 in IDLE, LOAD, DONE;
//    0 in GAP and RUN. First accept in IDLE/DONE clears done/timeout/overflow/counters
//    and that same word is written (counts as address 0).
//  - Write: registered; the cycle after accept, exactly one of icache_we/dcache_we is
//    high for one cycle with addr = per-target counter value, data = ld_data; counter
//    then +1. I and D counters independent, both start at 0 each session.
//  - Overflow: word for a target whose counter == DEPTH: no write, counter holds,
//    overflow<=1; word still accepted (stream never stalls).
//  - ld_last accepted -> GAP; start rises exactly START_GAP cycles after the final
//    write-enable pulse. ld_last on first word is legal (single-word session).
//  - RUN: start=1; cycle counter counts from 0. Each cycle: if (cpu_pc>>PC_SHIFT) >=
//    imem_count -> done<=1; else if counter == RUN_CYCLES-1 -> timeout<=1. Both
//    same cycle: done wins. Either event: start<=0 next cycle, state DONE.
//  - imem_count==0 entering RUN: done on first RUN cycle.
//  - rst mid-session: immediate return to reset values; partial load not resumed.
//  - Widths: counters ADDR_W bits; no wrap (DEPTH < 2**ADDR_W required).
// TESTING
//  1. Stream 9-word factorial program (I) with ld_last on word 8, START_GAP=2 ->
//     icache_we pulses addr 0..8, start high 2 cycles after addr 8, done when PC>=9,
//     $t0=120 for n=5.
//  2. Mixed stream I,D,I,D,D -> IAddr 0,1 and DAddr 0,1,2; no simultaneous we.
//  3. IMEM_DEPTH=4, send 6 I-words -> writes addr 0..3 only, overflow=1, imem_count=4.
//  4. Program "j 0" only, RUN_CYCLES=50 -> timeout=1 after 50 RUN cycles, done=0,
//     start low next cycle.
//  5. After DONE, new 3-word session -> flags cleared on first accept, addresses
//     restart at 0, second run completes with done=1.
//  6. Assert rst during RUN -> next cycle start=0, flags 0, ld_ready=1, state IDLE.

Source files
------------

// File: rtl/mips_program_loader.sv
// Boot/load sequencer: streams words into the I/D caches, then runs the
// processor until its PC leaves the loaded program or a cycle budget expires.
module mips_program_loader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter int unsigned START_GAP  = 2,
  parameter int unsigned RUN_CYCLES = 300,
  parameter int unsigned PC_SHIFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_dmem,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [DATA_W-1:0] IData_in,
  output logic [ADDR_W-1:0] IAddr_in,
  output logic              icache_we,
  output logic [DATA_W-1:0] DData_in,
  output logic [ADDR_W-1:0] DAddr_in,
  output logic              dcache_we,
  output logic              start,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W-1:0] imem_count
);

  localparam int unsigned GAP_W = (START_GAP  > 1) ? $clog2(START_GAP)  : 1;
  localparam int unsigned RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] dmem_count;
  logic [GAP_W-1:0]  gap_cnt;
  logic [RUN_W-1:0]  run_cnt;

  logic              accept;
  logic              session_start;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W-1:0] d_base;
  logic              i_full;
  logic              d_full;
  logic [ADDR_W-1:0] pc_word;
  logic              pc_exit;
  logic              gap_last;
  logic              run_last;

  assign ld_ready      = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
  assign accept        = ld_valid && ld_ready;
  assign session_start = accept && ((state == S_IDLE) || (state == S_DONE));

  // The first word of a session sees cleared counters so it lands at address 0.
  assign i_base  = session_start ? '0 : imem_count;
  assign d_base  = session_start ? '0 : dmem_count;
  assign i_full  = (i_base == ADDR_W'(IMEM_DEPTH));
  assign d_full  = (d_base == ADDR_W'(DMEM_DEPTH));

  assign pc_word  = cpu_pc >> PC_SHIFT;
  assign pc_exit  = (pc_word >= imem_count);
  assign gap_last = (gap_cnt == GAP_W'(START_GAP - 1));
  assign run_last = (run_cnt == RUN_W'(RUN_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_LOAD, S_DONE: if (accept) state_nx = ld_last ? S_GAP : S_LOAD;
      S_GAP:                  if (gap_last) state_nx = S_RUN;
      S_RUN:                  if (pc_exit || run_last) state_nx = S_DONE;
      default:                state_nx = S_IDLE;
    endcase
  end

  // Cache write pipeline, session counters, run supervision and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      IData_in   <= '0;
      IAddr_in   <= '0;
      icache_we  <= 1'b0;
      DData_in   <= '0;
      DAddr_in   <= '0;
      dcache_we  <= 1'b0;
      start      <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      imem_count <= '0;
      dmem_count <= '0;
      gap_cnt    <= '0;
      run_cnt    <= '0;
    end else begin
      icache_we <= 1'b0;
      dcache_we <= 1'b0;
      start     <= (state_nx == S_RUN);

      if (accept) begin
        imem_count <= i_base;
        dmem_count <= d_base;
        if (session_start) begin
          done     <= 1'b0;
          timeout  <= 1'b0;
          overflow <= 1'b0;
        end
        if (!ld_dmem) begin
          if (i_full) begin
            overflow <= 1'b1;
          end else begin
            icache_we  <= 1'b1;
            IAddr_in   <= i_base;
            IData_in   <= ld_data;
            imem_count <= i_base + 1'b1;
          end
        end else begin
          if (d_full) begin
            overflow <= 1'b1;
          end else begin
            dcache_we  <= 1'b1;
            DAddr_in   <= d_base;
            DData_in   <= ld_data;
            dmem_count <= d_base + 1'b1;
          end
        end
      end

      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      run_cnt <= (state == S_RUN) ? run_cnt + 1'b1 : '0;

      if (state == S_RUN) begin
        if (pc_exit)       done    <= 1'b1;
        else if (run_last) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader; the bench drives cpu_pc itself.
module tb_mips_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_dmem;
  logic        ld_last;
  logic [31:0] cpu_pc;
  logic [31:0] IData_in, IAddr_in, DData_in, DAddr_in;
  logic        icache_we, dcache_we;
  logic        start, done, timeout, overflow;
  logic [31:0] imem_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] fact [9];

  mips_program_loader #(
    .DATA_W(32), .ADDR_W(32), .IMEM_DEPTH(10), .DMEM_DEPTH(4),
    .START_GAP(2), .RUN_CYCLES(50), .PC_SHIFT(0)
  ) u_dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_dmem(ld_dmem), .ld_last(ld_last), .cpu_pc(cpu_pc),
    .IData_in(IData_in), .IAddr_in(IAddr_in), .icache_we(icache_we),
    .DData_in(DData_in), .DAddr_in(DAddr_in), .dcache_we(dcache_we),
    .start(start), .done(done), .timeout(timeout), .overflow(overflow),
    .imem_count(imem_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, then check the registered write pulse in the following cycle.
  task automatic send(input logic [31:0] data, input logic dm, input logic last,
                      input logic [31:0] exp_addr, input logic exp_we);
    check_eq("ready_before_send", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1; ld_data = data; ld_dmem = dm; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    if (!dm) begin
      check_eq("icache_we", {31'd0, icache_we}, {31'd0, exp_we});
      check_eq("dcache_we_quiet", {31'd0, dcache_we}, 32'd0);
      if (exp_we) begin
        check_eq("iaddr", IAddr_in, exp_addr);
        check_eq("idata", IData_in, data);
      end
    end else begin
      check_eq("dcache_we", {31'd0, dcache_we}, {31'd0, exp_we});
      check_eq("icache_we_quiet", {31'd0, icache_we}, 32'd0);
      if (exp_we) begin
        check_eq("daddr", DAddr_in, exp_addr);
        check_eq("ddata", DData_in, data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fact[0] = 32'h20040005; fact[1] = 32'h20080001; fact[2] = 32'h10800003;
    fact[3] = 32'h71044002; fact[4] = 32'h2084ffff; fact[5] = 32'h08000002;
    fact[6] = 32'h00000000; fact[7] = 32'h00000000; fact[8] = 32'h00000000;

    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_dmem = 1'b0; ld_last = 1'b0; cpu_pc = '0;
    step(); step();
    rst = 1'b0;
    check_eq("rst_ready", {31'd0, ld_ready}, 32'd1);
    check_eq("rst_start", {31'd0, start}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_we", {30'd0, icache_we, dcache_we}, 32'd0);
    check_eq("rst_imem_count", imem_count, 32'd0);

    // 1: nine-word program, start two cycles after last write, done on PC exit.
    for (int i = 0; i < 9; i++) send(fact[i], 1'b0, i == 8, i, 1'b1);
    step();
    check_eq("gap_start_low", {31'd0, start}, 32'd0);
    check_eq("gap_not_ready", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b1; ld_data = 32'hdeadbeef;
    step();
    ld_valid = 1'b0;
    check_eq("gap_word_ignored", {31'd0, icache_we}, 32'd0);
    check_eq("start_rise", {31'd0, start}, 32'd1);
    cpu_pc = 32'd4;
    step();
    check_eq("run_start_held", {31'd0, start}, 32'd1);
    check_eq("run_no_done", {31'd0, done}, 32'd0);
    cpu_pc = 32'd9;
    step();
    check_eq("t1_done", {31'd0, done}, 32'd1);
    check_eq("t1_start_low", {31'd0, start}, 32'd0);
    check_eq("t1_timeout", {31'd0, timeout}, 32'd0);
    check_eq("t1_imem_count", imem_count, 32'd9);

    // 2: mixed stream; PC already beyond the 2-word program -> done on first RUN cycle.
    send(32'h11, 1'b0, 1'b0, 32'd0, 1'b1);
    check_eq("t2_done_cleared", {31'd0, done}, 32'd0);
    send(32'h22, 1'b1, 1'b0, 32'd0, 1'b1);
    send(32'h33, 1'b0, 1'b0, 32'd1, 1'b1);
    send(32'h44, 1'b1, 1'b0, 32'd1, 1'b1);
    send(32'h55, 1'b1, 1'b1, 32'd2, 1'b1);
    check_eq("t2_imem_count", imem_count, 32'd2);
    step(); step();
    check_eq("t2_start", {31'd0, start}, 32'd1);
    step();
    check_eq("t2_done_first_cycle", {31'd0, done}, 32'd1);
    check_eq("t2_start_low", {31'd0, start}, 32'd0);

    // 3: twelve I-words into a 10-deep I-cache: last two dropped.
    for (int i = 0; i < 12; i++) send(32'h1000 + i, 1'b0, i == 11, i, i < 10);
    check_eq("t3_overflow", {31'd0, overflow}, 32'd1);
    check_eq("t3_imem_count", imem_count, 32'd10);
    cpu_pc = 32'd10;
    step(); step(); step();
    check_eq("t3_done", {31'd0, done}, 32'd1);

    // 4: single "j 0" word, PC stuck at 0 -> timeout after 50 RUN cycles.
    cpu_pc = 32'd0;
    send(32'h08000000, 1'b0, 1'b1, 32'd0, 1'b1);
    check_eq("t4_overflow_cleared", {31'd0, overflow}, 32'd0);
    check_eq("t4_done_cleared", {31'd0, done}, 32'd0);
    step(); step();
    check_eq("t4_start", {31'd0, start}, 32'd1);
    for (int i = 0; i < 49; i++) step();
    check_eq("t4_start_cycle50", {31'd0, start}, 32'd1);
    check_eq("t4_no_timeout_yet", {31'd0, timeout}, 32'd0);
    step();
    check_eq("t4_timeout", {31'd0, timeout}, 32'd1);
    check_eq("t4_done", {31'd0, done}, 32'd0);
    check_eq("t4_start_low", {31'd0, start}, 32'd0);

    // 5: new 3-word session after timeout, completes with done.
    send(32'hA0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_eq("t5_timeout_cleared", {31'd0, timeout}, 32'd0);
    send(32'hA1, 1'b0, 1'b0, 32'd1, 1'b1);
    send(32'hA2, 1'b0, 1'b1, 32'd2, 1'b1);
    step(); step();
    check_eq("t5_start", {31'd0, start}, 32'd1);
    cpu_pc = 32'd3;
    step();
    check_eq("t5_done", {31'd0, done}, 32'd1);
    check_eq("t5_timeout", {31'd0, timeout}, 32'd0);

    // 6: reset during RUN.
    cpu_pc = 32'd0;
    send(32'hB0, 1'b0, 1'b1, 32'd0, 1'b1);
    step(); step();
    check_eq("t6_start", {31'd0, start}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_start_low", {31'd0, start}, 32'd0);
    check_eq("t6_ready", {31'd0, ld_ready}, 32'd1);
    check_eq("t6_flags", {29'd0, done, timeout, overflow}, 32'd0);
    check_eq("t6_imem_count", imem_count, 32'd0);
    step();
    check_eq("t6_idle_start", {31'd0, start}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
